// File: rtl/xgriscv_muldiv_if.sv
// xgriscv_muldiv_if: request/response bundle between the EX stage and the mul/div unit
interface xgriscv_muldiv_if #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
);
   logic                   start;
   logic                   flush;
   logic [2:0]             op;
   logic [XLEN-1:0]        srca;
   logic [XLEN-1:0]        srcb;
   logic [RFIDX_WIDTH-1:0] rd_in;
   logic                   stall;
   logic                   busy;
   logic                   done;
   logic [XLEN-1:0]        result;
   logic [RFIDX_WIDTH-1:0] rd_out;
   modport master (
      output start, flush, op, srca, srcb, rd_in,
      input  stall, busy, done, result, rd_out
   );
   modport slave (
      input  start, flush, op, srca, srcb, rd_in,
      output stall, busy, done, result, rd_out
   );
endinterface

// File: rtl/xgriscv_muldiv.sv
// xgriscv_muldiv: iterative radix-2 multiplier / restoring divider for RV32M
module xgriscv_muldiv #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
) (
   input logic             clk,
   input logic             reset,
   xgriscv_muldiv_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             op_q, op_d;
   logic [RFIDX_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
   logic [XLEN-1:0]        b_q, b_d, res_q, res_d;
   logic [2*XLEN-1:0]      p_q, p_d;
   logic                   neg_q, neg_d, nrem_q, nrem_d;
   logic                   accept, is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, last;
   logic [XLEN-1:0]        a_mag, b_mag, spec_res, quo, rem, fin;
   logic [XLEN:0]          mul_sum, div_try;
   logic [2*XLEN-1:0]      p_next, prod;
   assign accept   = (state_q == IDLE) & bus.start & ~bus.flush;
   assign is_div   = bus.op[2];
   assign a_sgn    = is_div ? ~bus.op[0] : (bus.op[1] ^ bus.op[0]);
   assign b_sgn    = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
   assign a_neg    = a_sgn & bus.srca[XLEN-1];
   assign b_neg    = b_sgn & bus.srcb[XLEN-1];
   assign a_mag    = a_neg ? -bus.srca : bus.srca;
   assign b_mag    = b_neg ? -bus.srcb : bus.srcb;
   assign div0     = is_div & (bus.srcb == '0);
   assign ovf      = is_div & ~bus.op[0] & (bus.srca == MIN_NEG) & (bus.srcb == '1);
   assign spec_res = div0 ? (bus.op[1] ? bus.srca : '1) : (bus.op[1] ? '0 : MIN_NEG);
   assign last     = cnt_q == CW'(XLEN - 1);
   // p_q holds {high, multiplier} for mul and {partial remainder, dividend/quotient} for div
   assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
   assign div_try  = p_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
   assign p_next   = ~op_q[2] ? {mul_sum, p_q[XLEN-1:1]} :
                     div_try[XLEN] ? {p_q[2*XLEN-2:0], 1'b0} :
                     {div_try[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
   assign prod     = neg_q ? -p_next : p_next;
   assign quo      = neg_q ? -p_next[XLEN-1:0] : p_next[XLEN-1:0];
   assign rem      = nrem_q ? -p_next[2*XLEN-1:XLEN] : p_next[2*XLEN-1:XLEN];
   assign fin      = op_q[2] ? (op_q[1] ? rem : quo) :
                     (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   assign bus.stall  = reset & (accept | (state_q == CALC));
   assign bus.busy   = (state_q == CALC) | (state_q == DONE);
   assign bus.done   = (state_q == DONE) & ~bus.flush;
   assign bus.result = res_q;
   assign bus.rd_out = rd_out_q;
   // Next state: zero divisor and signed overflow bypass the iterations
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? ((div0 | ovf) ? DONE : CALC) : IDLE;
         CALC:    state_d = bus.flush ? IDLE : (last ? DONE : CALC);
         default: state_d = IDLE;
      endcase
   end
   // Datapath: latch magnitudes on accept, one step per CALC cycle, sign fix-up on the last step
   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      b_d      = b_q;
      p_d      = p_q;
      neg_d    = neg_q;
      nrem_d   = nrem_q;
      res_d    = res_q;
      rd_out_d = rd_out_q;
      if (accept) begin
         cnt_d  = '0;
         op_d   = bus.op;
         rd_d   = bus.rd_in;
         b_d    = b_mag;
         p_d    = {{XLEN{1'b0}}, a_mag};
         neg_d  = a_neg ^ b_neg;
         nrem_d = a_neg;
         if (div0 | ovf) begin
            res_d    = spec_res;
            rd_out_d = bus.rd_in;
         end
      end else if ((state_q == CALC) && !bus.flush) begin
         p_d = p_next;
         if (last) begin
            res_d    = fin;
            rd_out_d = rd_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end
   // State and datapath registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         b_q      <= '0;
         p_q      <= '0;
         neg_q    <= 1'b0;
         nrem_q   <= 1'b0;
         res_q    <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         b_q      <= b_d;
         p_q      <= p_d;
         neg_q    <= neg_d;
         nrem_q   <= nrem_d;
         res_q    <= res_d;
         rd_out_q <= rd_out_d;
      end
   end
endmodule

// File: tb/tb_xgriscv_muldiv.sv
// tb_xgriscv_muldiv: directed vector bench for the iterative mul/div unit
module tb_xgriscv_muldiv;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   applied = 0;
   int   errs = 0;
   xgriscv_muldiv_if #(.XLEN(32), .RFIDX_WIDTH(5)) bus ();
   xgriscv_muldiv #(.XLEN(32), .RFIDX_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t v[17];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   // Issue one operation at the current negedge and follow it to done (bounded)
   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, output int lat, output logic [31:0] res,
                      output logic [4:0] rdo, output logic stall_ok);
      int cyc;
      cyc = 1;
      stall_ok = 1'b1;
      bus.start = 1'b1;
      bus.op = op;
      bus.srca = a;
      bus.srcb = b;
      bus.rd_in = rd;
      #1 if (!bus.stall) stall_ok = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 2;
      #1;
      while (!bus.done && cyc < 60) begin
         if (!bus.stall) stall_ok = 1'b0;
         @(negedge clk);
         #1;
         cyc++;
      end
      lat = bus.done ? cyc : -1;
      if (bus.stall) stall_ok = 1'b0;
      res = bus.result;
      rdo = bus.rd_out;
   endtask
   initial begin
      int lat;
      logic [31:0] res;
      logic [4:0] rdo;
      logic sok;
      logic seen;
      v[0]  = '{3'd0, 32'd7,        32'd6,        32'd42,       34};
      v[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
      v[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      v[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
      v[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
      v[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
      v[6]  = '{3'd5, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 34};
      v[7]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
      v[8]  = '{3'd7, 32'd5,        32'd0,        32'd5,        2};
      v[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
      v[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
      v[11] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34};
      v[12] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        34};
      v[13] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
      v[14] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
      v[15] = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
      v[16] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2};
      bus.start = 1'b1;
      bus.flush = 1'b0;
      bus.op = 3'd0;
      bus.srca = 32'd7;
      bus.srcb = 32'd6;
      bus.rd_in = 5'd5;
      #3;
      chk("reset_stall", {31'd0, bus.stall}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      chk("reset_rd_out", {27'd0, bus.rd_out}, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         run(v[i].op, v[i].a, v[i].b, 5'(i + 5), lat, res, rdo, sok);
         chk($sformatf("v%0d_result", i), res, v[i].exp);
         chk($sformatf("v%0d_rd_out", i), {27'd0, rdo}, 32'(i + 5));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("v%0d_stall", i), {31'd0, sok}, 32'd1);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
         chk($sformatf("v%0d_hold", i), bus.result, v[i].exp);
      end
      bus.start = 1'b1;
      bus.op = 3'd4;
      bus.srca = 32'd100;
      bus.srcb = 32'd3;
      bus.rd_in = 5'd9;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 1'b0;
      for (int c = 2; c < 10; c++) begin
         @(negedge clk);
         #1 seen |= bus.done;
      end
      bus.flush = 1'b1;
      #1 chk("flush_busy_before", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("flush_busy_after", {31'd0, bus.busy}, 32'd0);
      chk("flush_stall_after", {31'd0, bus.stall}, 32'd0);
      chk("flush_no_done", {31'd0, seen | bus.done}, 32'd0);
      chk("flush_result_kept", bus.result, 32'hFFFFFFFB);
      run(3'd0, 32'd3, 32'd3, 5'd7, lat, res, rdo, sok);
      chk("post_flush_result", res, 32'd9);
      chk("post_flush_rd_out", {27'd0, rdo}, 32'd7);
      chk("post_flush_latency", 32'(lat), 32'd34);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'd0;
      bus.srca = 32'd1000;
      bus.srcb = 32'd1000;
      bus.rd_in = 5'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (13) @(negedge clk);
      #1 chk("rst_busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1 seen |= bus.done | bus.busy;
      end
      chk("rst_no_done", {31'd0, seen}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
      $finish;
   end
endmodule

// File: doc/xgriscv_muldiv.md
XGRISCV_MULDIV -- requirements
Module: xgriscv_muldiv

Interface
- REQ-001 The block SHALL have parameter XLEN, default 32: operand and result width.
- REQ-002 The block SHALL have parameter RFIDX_WIDTH, default 5: destination register index width.
- REQ-003 The block SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port reset  input  1: asynchronous, active-low reset.
- REQ-005 The block SHALL have port start  input  1: request a new operation (EX stage).
- REQ-006 The block SHALL have port flush  input  1: abort the operation in flight (branch/jump redirect).
- REQ-007 The block SHALL have port op  input  3: funct3 encoding, 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- REQ-008 The block SHALL have ports srca and srcb  input  XLEN: rs1 and rs2 operands after forwarding.
- REQ-009 The block SHALL have port rd_in  input  RFIDX_WIDTH: destination index of the request.
- REQ-010 The block SHALL have port stall  output  1: holds the IF/ID/EX pipeline registers.
- REQ-011 The block SHALL have port busy  output  1: high while in state CALC or DONE.
- REQ-012 The block SHALL have port done  output  1: one-cycle result-valid pulse.
- REQ-013 The block SHALL have port result  output  XLEN: operation result.
- REQ-014 The block SHALL have port rd_out  output  RFIDX_WIDTH: destination index latched at start.

Function
- REQ-015 The FSM SHALL have the states IDLE, CALC and DONE.
- REQ-016 In IDLE with start=1 and flush=0, the block SHALL latch op, rd_in and the operand magnitudes, clear the iteration counter and enter CALC.
- REQ-017 Signed operands (MULH: both; MULHSU: srca only; DIV/REM: both) SHALL be converted to magnitude, and the result sign SHALL be restored on entry to DONE.
- REQ-018 CALC SHALL perform one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle for exactly XLEN cycles, then enter DONE.
- REQ-019 The counter SHALL be ceil(log2(XLEN))+1 bits wide and SHALL not wrap; a terminal count of XLEN-1 selects DONE.
- REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
- REQ-021 Latency SHALL be start accepted at edge T -> done high in the cycle after edge T+XLEN+1, which is XLEN+2 cycles for XLEN=32 (34 cycles).
- REQ-022 Divide by zero SHALL skip CALC and enter DONE at T+1, with quotient all-ones and remainder equal to srca.
- REQ-023 Signed overflow (DIV/REM of -2^(XLEN-1) by -1) SHALL skip CALC, with quotient -2^(XLEN-1) and remainder 0.
- REQ-024 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
- REQ-025 The remainder sign SHALL equal the dividend sign, and the quotient SHALL truncate toward zero.
- REQ-026 stall SHALL equal (IDLE & start & ~flush) | CALC, and SHALL be low in DONE so the pipeline advances with the result.
- REQ-027 start while in CALC or DONE SHALL be ignored.
- REQ-028 flush in CALC or DONE SHALL force IDLE at the next edge with no done pulse.
- REQ-029 flush together with start in IDLE SHALL mean flush wins and nothing is latched.
- REQ-030 result and rd_out SHALL hold their last values until the next DONE.

Reset
- REQ-031 reset=0 SHALL immediately, without a clock, force IDLE and drive stall=0, busy=0, done=0, result=0, rd_out=0, and clear the counter and operand registers.
- REQ-032 Reset asserted mid-operation SHALL discard the operation, with no done pulse after release.
- REQ-033 The first start SHALL be accepted on the first rising edge after reset releases.

Verification (XLEN=32)
- REQ-034 The bench SHALL check: MUL 7 x 6, rd_in=5 -> done in cycle 34, result=42, rd_out=5, stall high for cycles 1-33.
- REQ-035 The bench SHALL check: MULH 0x80000000 x 0x80000000 -> result=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- REQ-036 The bench SHALL check: DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
- REQ-037 The bench SHALL check: DIVU 5/0 -> done in cycle 2, result 0xFFFFFFFF; REMU 5%0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- REQ-038 The bench SHALL check: flush in cycle 10 of a DIV -> busy=0 and stall=0 next cycle, no done; a new MUL 3 x 3 started next is accepted and gives 9.
- REQ-039 The bench SHALL check: reset low in cycle 15 of a MUL -> all outputs 0 at once; after release, no done appears within 40 cycles without a new start.
